// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle control sequencer for the RV32I-subset core.
// Each instruction steps through FETCH, DECODE, EXEC, MEM and WB. The sequencer
// issues per-state strobes to the shared datapath and waits on a memory ready
// handshake in FETCH and MEM.
//
// Optional feature macro: MC_ILLEGAL_TRAP_EN
//   defined   : an unsupported instruction parks the sequencer in TRAP with illegal=1
//   undefined : an unsupported instruction retires as a 3-cycle NOP
//
// Ports:
//   clk, reset                  clock (rising edge), async active-high reset
//   Op, Funct7, Funct3          instruction fields from the datapath IR
//   Zero                        ALU zero flag (used by beq in EXEC)
//   mem_ready                   memory completes the current request this cycle
//   mem_req, MemRead, MemWrite  memory request and qualifiers
//   IRWrite, PCWrite, RegWrite  datapath load/write enables
//   EXTOp, ALUOp, NPCOp         immediate type, ALU operation, next-PC select
//   ALUSrc, WDSel               ALU B operand select, register write-data select
//   state, illegal, instret     debug state, illegal flag, retired count
module multicycle_ctrl #(
    parameter int unsigned INSTRET_W = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [6:0]           Op,
    input  logic [6:0]           Funct7,
    input  logic [2:0]           Funct3,
    input  logic                 Zero,
    input  logic                 mem_ready,
    output logic                 mem_req,
    output logic                 IRWrite,
    output logic                 PCWrite,
    output logic                 RegWrite,
    output logic                 MemWrite,
    output logic                 MemRead,
    output logic [5:0]           EXTOp,
    output logic [4:0]           ALUOp,
    output logic [2:0]           NPCOp,
    output logic                 ALUSrc,
    output logic [1:0]           WDSel,
    output logic [2:0]           state,
    output logic                 illegal,
    output logic [INSTRET_W-1:0] instret
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    // C_NOP doubles as the "unsupported instruction" class
    typedef enum logic [2:0] {
        C_NOP, C_LW, C_SW, C_ALU_R, C_ALU_I, C_BEQ, C_JAL, C_JALR
    } cls_t;

    localparam logic [4:0] ALU_ADD = 5'b00011;
    localparam logic [4:0] ALU_SUB = 5'b00100;
    localparam logic [4:0] ALU_XOR = 5'b01100;
    localparam logic [4:0] ALU_OR  = 5'b01101;
    localparam logic [4:0] ALU_AND = 5'b01110;

    localparam logic [5:0] EXT_I = 6'b010000;
    localparam logic [5:0] EXT_S = 6'b001000;
    localparam logic [5:0] EXT_B = 6'b000100;
    localparam logic [5:0] EXT_J = 6'b000001;

    localparam logic [2:0] NPC_PLUS4  = 3'b000;
    localparam logic [2:0] NPC_BRANCH = 3'b001;
    localparam logic [2:0] NPC_JUMP   = 3'b010;
    localparam logic [2:0] NPC_JALR   = 3'b100;

    localparam logic [1:0] WD_ALU = 2'b00;
    localparam logic [1:0] WD_MEM = 2'b01;
    localparam logic [1:0] WD_PC  = 2'b10;

    state_t               state_r;
    cls_t                 cls_r;
    logic [4:0]           alu_r;
    logic [INSTRET_W-1:0] instret_r;
    cls_t                 dec_cls;
    logic [4:0]           dec_alu;

    assign state   = state_r;
    assign instret = instret_r;

    // Instruction classification from the live IR fields (consumed in DECODE)
    always_comb begin
        dec_cls = C_NOP;
        dec_alu = 5'd0;
        case (Op)
            7'b0000011: if (Funct3 == 3'b010) begin dec_cls = C_LW; dec_alu = ALU_ADD; end
            7'b0100011: if (Funct3 == 3'b010) begin dec_cls = C_SW; dec_alu = ALU_ADD; end
            7'b0110011: begin
                case ({Funct7, Funct3})
                    10'b0000000_000: begin dec_cls = C_ALU_R; dec_alu = ALU_ADD; end
                    10'b0100000_000: begin dec_cls = C_ALU_R; dec_alu = ALU_SUB; end
                    10'b0000000_100: begin dec_cls = C_ALU_R; dec_alu = ALU_XOR; end
                    10'b0000000_110: begin dec_cls = C_ALU_R; dec_alu = ALU_OR;  end
                    10'b0000000_111: begin dec_cls = C_ALU_R; dec_alu = ALU_AND; end
                    default: ;
                endcase
            end
            7'b0010011: begin
                case (Funct3)
                    3'b000: begin dec_cls = C_ALU_I; dec_alu = ALU_ADD; end
                    3'b100: begin dec_cls = C_ALU_I; dec_alu = ALU_XOR; end
                    3'b110: begin dec_cls = C_ALU_I; dec_alu = ALU_OR;  end
                    3'b111: begin dec_cls = C_ALU_I; dec_alu = ALU_AND; end
                    default: ;
                endcase
            end
            7'b1100011: if (Funct3 == 3'b000) begin dec_cls = C_BEQ; dec_alu = ALU_SUB; end
            7'b1101111: dec_cls = C_JAL;
            7'b1100111: if (Funct3 == 3'b000) begin dec_cls = C_JALR; dec_alu = ALU_ADD; end
            default: ;
        endcase
    end

    // State, latched class and retire counter; class is frozen when leaving DECODE
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= S_FETCH;
            cls_r     <= C_NOP;
            alu_r     <= 5'd0;
            instret_r <= '0;
        end else begin
            if (PCWrite) instret_r <= instret_r + INSTRET_W'(1);
            case (state_r)
                S_FETCH:  if (mem_ready) state_r <= S_DECODE;
                S_DECODE: begin
                    cls_r <= dec_cls;
                    alu_r <= dec_alu;
                    if (dec_cls != C_NOP) begin
                        state_r <= S_EXEC;
                    end else begin
`ifdef MC_ILLEGAL_TRAP_EN
                        state_r <= S_TRAP;
`else
                        state_r <= S_WB;
`endif
                    end
                end
                S_EXEC: begin
                    case (cls_r)
                        C_LW, C_SW:       state_r <= S_MEM;
                        C_ALU_R, C_ALU_I: state_r <= S_WB;
                        default:          state_r <= S_FETCH;
                    endcase
                end
                S_MEM:    if (mem_ready) state_r <= (cls_r == C_LW) ? S_WB : S_FETCH;
                S_WB:     state_r <= S_FETCH;
`ifdef MC_ILLEGAL_TRAP_EN
                S_TRAP:   state_r <= S_TRAP;
`endif
                default:  state_r <= S_FETCH;
            endcase
        end
    end

    // Per-state strobes; everything is held at 0 while reset is high
    always_comb begin
        mem_req  = 1'b0;
        IRWrite  = 1'b0;
        PCWrite  = 1'b0;
        RegWrite = 1'b0;
        MemWrite = 1'b0;
        MemRead  = 1'b0;
        EXTOp    = 6'd0;
        ALUOp    = 5'd0;
        NPCOp    = NPC_PLUS4;
        ALUSrc   = 1'b0;
        WDSel    = WD_ALU;
        illegal  = 1'b0;
        if (!reset) begin
            case (state_r)
                S_FETCH: begin
                    mem_req = 1'b1;
                    MemRead = 1'b1;
                    IRWrite = mem_ready;
                end
                S_EXEC: begin
                    ALUOp  = alu_r;
                    ALUSrc = cls_r inside {C_LW, C_SW, C_ALU_I, C_JALR};
                    case (cls_r)
                        C_LW, C_ALU_I: EXTOp = EXT_I;
                        C_SW:          EXTOp = EXT_S;
                        C_BEQ: begin
                            EXTOp   = EXT_B;
                            PCWrite = 1'b1;
                            NPCOp   = Zero ? NPC_BRANCH : NPC_PLUS4;
                        end
                        C_JAL: begin
                            EXTOp    = EXT_J;
                            RegWrite = 1'b1;
                            WDSel    = WD_PC;
                            PCWrite  = 1'b1;
                            NPCOp    = NPC_JUMP;
                        end
                        C_JALR: begin
                            EXTOp    = EXT_I;
                            RegWrite = 1'b1;
                            WDSel    = WD_PC;
                            PCWrite  = 1'b1;
                            NPCOp    = NPC_JALR;
                        end
                        default: ;
                    endcase
                end
                S_MEM: begin
                    mem_req  = 1'b1;
                    MemRead  = (cls_r == C_LW);
                    MemWrite = (cls_r == C_SW);
                    PCWrite  = (cls_r == C_SW) && mem_ready;
                end
                S_WB: begin
                    // ALU result is not registered, so arithmetic ops keep the ALU steered
                    RegWrite = (cls_r != C_NOP);
                    PCWrite  = 1'b1;
                    WDSel    = (cls_r == C_LW) ? WD_MEM : WD_ALU;
                    if (cls_r inside {C_ALU_R, C_ALU_I}) begin
                        ALUOp  = alu_r;
                        ALUSrc = (cls_r == C_ALU_I);
                        EXTOp  = (cls_r == C_ALU_I) ? EXT_I : 6'd0;
                    end
                end
`ifdef MC_ILLEGAL_TRAP_EN
                S_TRAP:  illegal = 1'b1;
`endif
                default: ;
            endcase
        end
    end

endmodule
